emu_cen_gen: RTL

Parametrised multi-channel fractional clock-enable generator for the emulator top level, replacing the fixed-ratio divider in the simulation and FPGA wrappers. Each channel produces a single-cycle `cen` pulse at rate `num/den` of `clk_sys`. Per-channel controls:
- a runtime turbo mode, which doubles the rate and replaces the build-time "fast video" hack;
- pause gating, so the CPU domain freezes while video keeps running.

---
 rtl/emu_cen_pkg.sv | 30 +++
 rtl/emu_cen_chan.sv | 67 ++++++
 rtl/emu_cen_gen.sv | 50 +++++
 3 files changed

// File: rtl/emu_cen_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// emu_cen_pkg -- shared types and step clamp for emu_cen_gen.   Rev 1.0
// ----------------------------------------------------------------------------
package emu_cen_pkg;

  localparam int ACC_W_DEF  = 16;
  // Widest num/den the clamp helper accepts; callers zero-extend into it.
  localparam int STEP_MAX_W = 32;

  typedef struct packed {
    logic [ACC_W_DEF-1:0] num;
    logic [ACC_W_DEF-1:0] den;
  } cen_cfg_t;

  function automatic logic [STEP_MAX_W:0] cen_step(
    input logic [STEP_MAX_W-1:0] num,
    input logic [STEP_MAX_W-1:0] den,
    input logic                  turbo
  );
    logic [STEP_MAX_W:0] raw;
    raw = turbo ? {num, 1'b0} : {1'b0, num};
    if (raw > {1'b0, den}) begin
      raw = {1'b0, den};
    end
    return raw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/emu_cen_chan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// emu_cen_chan -- one fractional clock-enable channel with hold.  Rev 1.0
// ----------------------------------------------------------------------------
module emu_cen_chan
  import emu_cen_pkg::*;
#(
  parameter int               ACC_W   = ACC_W_DEF,
  parameter logic [ACC_W-1:0] DEF_NUM = ACC_W'(1),
  parameter logic [ACC_W-1:0] DEF_DEN = ACC_W'(4)
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             hold,
  input  logic             turbo,
  input  logic             cfg_wr,
  input  logic [ACC_W-1:0] cfg_num,
  input  logic [ACC_W-1:0] cfg_den,
  output logic             cen,
  output logic [ACC_W-1:0] cnt
);

  localparam int STEP_W = ACC_W + 1;

  logic [ACC_W-1:0] num_r;
  logic [ACC_W-1:0] den_r;
  logic [ACC_W:0]   acc;
  logic [ACC_W:0]   step;
  logic [ACC_W:0]   acc_wrap;
  logic [ACC_W+1:0] sum;
  logic             disabled;

  assign disabled = (num_r == '0) || (den_r == '0);
  assign step     = STEP_W'(cen_step(STEP_MAX_W'(num_r), STEP_MAX_W'(den_r), turbo));
  assign sum      = {1'b0, acc} + {1'b0, step};
  // step <= den keeps acc < den, so the wrapped remainder always fits ACC_W+1 bits.
  assign acc_wrap = sum[ACC_W:0] - {1'b0, den_r};

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      num_r <= DEF_NUM;
      den_r <= DEF_DEN;
      acc   <= '0;
      cen   <= 1'b0;
      cnt   <= '0;
    end else if (cfg_wr) begin
      num_r <= cfg_num;
      den_r <= cfg_den;
      acc   <= '0;
      cen   <= 1'b0;
    end else if (hold) begin
      cen   <= 1'b0;
    end else if (disabled) begin
      acc   <= '0;
      cen   <= 1'b0;
    end else if (sum >= {2'b00, den_r}) begin
      acc   <= acc_wrap;
      cen   <= 1'b1;
      cnt   <= cnt + ACC_W'(1);
    end else begin
      acc   <= sum[ACC_W:0];
      cen   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/emu_cen_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// emu_cen_gen -- multi-channel fractional clock-enable generator. Rev 1.0
// ----------------------------------------------------------------------------
module emu_cen_gen
  import emu_cen_pkg::*;
#(
  parameter int                         CHANNELS = 2,
  parameter int                         ACC_W    = ACC_W_DEF,
  parameter logic [CHANNELS*ACC_W-1:0]  DEF_NUM  = {CHANNELS{16'd1}},
  parameter logic [CHANNELS*ACC_W-1:0]  DEF_DEN  = {CHANNELS{16'd4}},
  localparam int                        SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        pause,
  input  logic [CHANNELS-1:0]         pause_mask,
  input  logic [CHANNELS-1:0]         turbo,
  input  logic                        cfg_wr,
  input  logic [SEL_W-1:0]            cfg_sel,
  input  logic [ACC_W-1:0]            cfg_num,
  input  logic [ACC_W-1:0]            cfg_den,
  output logic [CHANNELS-1:0]         cen,
  output logic [CHANNELS*ACC_W-1:0]   cen_cnt
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic wr;
    // Compare at 32 bits so selector codes beyond the last channel match nothing.
    assign wr = cfg_wr && (32'(cfg_sel) == i);

    emu_cen_chan #(
      .ACC_W   (ACC_W),
      .DEF_NUM (DEF_NUM[i*ACC_W +: ACC_W]),
      .DEF_DEN (DEF_DEN[i*ACC_W +: ACC_W])
    ) u_chan (
      .clk_sys (clk_sys),
      .reset   (reset),
      .hold    (pause && pause_mask[i]),
      .turbo   (turbo[i]),
      .cfg_wr  (wr),
      .cfg_num (cfg_num),
      .cfg_den (cfg_den),
      .cen     (cen[i]),
      .cnt     (cen_cnt[i*ACC_W +: ACC_W])
    );
  end

endmodule
`default_nettype wire
